// File: rtl/dds_pkg.sv
// dds_pkg: shared constants and arbitration helper for the DDS sample path
package dds_pkg;
    localparam int N_REQ = 4;
    localparam int SEL_W = 2;
    localparam logic [SEL_W-1:0] LAST_RST = 2'd3;

    // Scanning from the far end lets the nearest asserted candidate win last.
    function automatic logic [SEL_W-1:0] pick_winner(
        input logic [N_REQ-1:0] req,
        input logic [SEL_W-1:0] last,
        input logic             fixed_pri
    );
        logic [SEL_W-1:0] w;
        logic [SEL_W-1:0] idx;
        w = last;
        if (fixed_pri) begin
            for (int k = N_REQ - 1; k >= 0; k--)
                if (req[k]) w = SEL_W'(k);
        end else begin
            for (int k = N_REQ; k >= 1; k--) begin
                idx = last + SEL_W'(k);
                if (req[idx]) w = idx;
            end
        end
        return w;
    endfunction
endpackage

// File: rtl/mux_4.sv
// mux_4: four-way data selector
module mux_4 #(
    parameter int m = 12
) (
    input  logic [1:0]   sel,
    input  logic [m-1:0] d0,
    input  logic [m-1:0] d1,
    input  logic [m-1:0] d2,
    input  logic [m-1:0] d3,
    output logic [m-1:0] y
);
    always_comb
        y = sel[1] ? (sel[0] ? d3 : d2) : (sel[0] ? d1 : d0);
endmodule

// File: rtl/sample_arbiter_4.sv
// sample_arbiter_4: round-robin/fixed-priority arbiter feeding one registered
// sample stage with a valid/ready handshake toward the mixer.
module sample_arbiter_4
    import dds_pkg::*;
#(
    parameter int M = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fixed_pri,
    input  logic [N_REQ-1:0] req,
    input  logic [M-1:0]     data0,
    input  logic [M-1:0]     data1,
    input  logic [M-1:0]     data2,
    input  logic [M-1:0]     data3,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             out_valid,
    output logic [M-1:0]     out_data,
    output logic [SEL_W-1:0] out_src,
    input  logic             out_ready
);
    logic [SEL_W-1:0] last;
    logic [M-1:0]     mux_out;
    logic             space;
    logic             load;

    mux_4 #(.m(M)) u_mux (
        .sel(sel),
        .d0 (data0),
        .d1 (data1),
        .d2 (data2),
        .d3 (data3),
        .y  (mux_out)
    );

    // Grants are masked during reset so nothing is handed out while the stage is cleared.
    always_comb begin
        space = !out_valid || out_ready;
        sel   = (|req) ? pick_winner(req, last, fixed_pri) : last;
        load  = (|req) && space && !rst;
        gnt   = load ? N_REQ'(1) << sel : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            last      <= LAST_RST;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= mux_out;
            out_src   <= sel;
            last      <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sample_arbiter_4.sv
// tb_sample_arbiter_4: directed vectors with hand-computed expectations
module tb_sample_arbiter_4;
    logic        clk = 1'b0;
    logic        rst;
    logic        fixed_pri;
    logic [3:0]  req;
    logic [11:0] data0, data1, data2, data3;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        out_valid;
    logic [11:0] out_data;
    logic [1:0]  out_src;
    logic        out_ready;
    int          errors = 0;
    int          checks = 0;

    sample_arbiter_4 #(.M(12)) dut (
        .clk(clk), .rst(rst), .fixed_pri(fixed_pri), .req(req),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3),
        .gnt(gnt), .sel(sel), .out_valid(out_valid), .out_data(out_data),
        .out_src(out_src), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        logic [11:0] d [4];
        int          seq_a [4];
        int          seq_b [4];
        d     = '{12'h111, 12'h222, 12'h333, 12'h444};
        seq_a = '{2, 0, 2, 0};
        seq_b = '{1, 3, 1, 3};
        rst = 1'b1; fixed_pri = 1'b0; out_ready = 1'b1; req = 4'b1111;
        data0 = d[0]; data1 = d[1]; data2 = d[2]; data3 = d[3];
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_src", 32'(out_src), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        @(negedge clk); rst = 1'b0;
        // round-robin with all requesters active
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("rr_gnt", 32'(gnt), 32'(4'b1 << (i % 4)));
            chk("rr_sel", 32'(sel), 32'(i % 4));
            @(posedge clk); #1;
            chk("rr_data", 32'(out_data), 32'(d[i % 4]));
            chk("rr_src", 32'(out_src), 32'(i % 4));
            chk("rr_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        // backpressure hold
        req = 4'b0000;
        @(posedge clk); #1;
        chk("drain_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        req = 4'b0001; data0 = 12'h0A5; out_ready = 1'b0;
        #1 chk("bp_gnt", 32'(gnt), 32'b0001);
        @(posedge clk); #1;
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_data", 32'(out_data), 32'h0A5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("bp_hold_gnt", 32'(gnt), 32'd0);
            @(posedge clk); #1;
            chk("bp_hold_data", 32'(out_data), 32'h0A5);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk); out_ready = 1'b1;
        #1 chk("bp_release_gnt", 32'(gnt), 32'b0001);
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        // fixed priority, then switch back to round-robin
        fixed_pri = 1'b1; req = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            #1 chk("fp_gnt", 32'(gnt), 32'b0001);
            @(posedge clk); #1;
            chk("fp_src", 32'(out_src), 32'd0);
            @(negedge clk);
        end
        fixed_pri = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("sw_gnt", 32'(gnt), 32'(4'b1 << seq_a[i]));
            @(posedge clk); #1;
            chk("sw_src", 32'(out_src), 32'(seq_a[i]));
            @(negedge clk);
        end
        req = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1 chk("odd_gnt", 32'(gnt), 32'(4'b1 << seq_b[i]));
            @(posedge clk); #1;
            chk("odd_src", 32'(out_src), 32'(seq_b[i]));
            @(negedge clk);
        end
        // back-to-back drain and load
        req = 4'b0001; data0 = 12'h055;
        @(posedge clk); #1;
        chk("b2b_pre_src", 32'(out_src), 32'd0);
        @(negedge clk);
        req = 4'b0100; data2 = 12'hFFF;
        #1 chk("b2b_gnt", 32'(gnt), 32'b0100);
        @(posedge clk); #1;
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_data", 32'(out_data), 32'hFFF);
        chk("b2b_src", 32'(out_src), 32'd2);
        // asynchronous reset mid-stream
        @(negedge clk); req = 4'b1111;
        @(posedge clk); #1;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_data", 32'(out_data), 32'd0);
        chk("async_gnt", 32'(gnt), 32'd0);
        @(negedge clk); req = 4'b0000;
        #1 chk("idle_sel", 32'(sel), 32'd3);
        req = 4'b1111; rst = 1'b0;
        #1 chk("post_rst_gnt", 32'(gnt), 32'b0001);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
